// File: rtl/io_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : io_arbiter_pkg
// Brief  : Shared types, constants and helpers for the I/O bus arbiter.
// Rev    : 1.0
// ============================================================================
package io_arbiter_pkg;

    localparam int IO_MAX_REQUESTERS = 8;
    localparam int IO_ADDR_W         = 32;
    localparam int IO_DATA_W         = 32;

    // Sized for the largest legal requester count so every instance shares one index type.
    localparam int IO_REQ_IDX_W = (IO_MAX_REQUESTERS > 2) ? $clog2(IO_MAX_REQUESTERS) : 1;

    typedef logic [IO_REQ_IDX_W-1:0] io_requester_idx_t;

    // Round-robin successor; wraps explicitly so non-power-of-two counts work.
    function automatic io_requester_idx_t io_next_ptr(input io_requester_idx_t idx, input int num);
        io_requester_idx_t nxt;
        if (int'(idx) == num - 1) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : io_arbiter_if
// Brief  : Requester-side handshake plus peripheral-side I/O bus signals.
// Rev    : 1.0
// ============================================================================
interface io_arbiter_if #(
    parameter int NUM_REQUESTERS = 4
);
    import io_arbiter_pkg::*;

    logic [NUM_REQUESTERS-1:0]                req;
    logic [NUM_REQUESTERS-1:0]                req_write;
    logic [NUM_REQUESTERS-1:0][IO_ADDR_W-1:0] req_address;
    logic [NUM_REQUESTERS-1:0][IO_DATA_W-1:0] req_write_data;
    logic [NUM_REQUESTERS-1:0]                grant;
    logic [NUM_REQUESTERS-1:0]                resp_valid;
    logic [IO_DATA_W-1:0]                     resp_data;
    logic                                     io_write_en;
    logic                                     io_read_en;
    logic [IO_ADDR_W-1:0]                     io_address;
    logic [IO_DATA_W-1:0]                     io_write_data;
    logic [IO_DATA_W-1:0]                     io_read_data;

    modport slave (
        input  req, req_write, req_address, req_write_data, io_read_data,
        output grant, resp_valid, resp_data,
        output io_write_en, io_read_en, io_address, io_write_data
    );

    modport master (
        output req, req_write, req_address, req_write_data, io_read_data,
        input  grant, resp_valid, resp_data,
        input  io_write_en, io_read_en, io_address, io_write_data
    );

endinterface
`default_nettype wire

// File: rtl/io_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : io_rr_arbiter
// Brief  : Combinational round-robin pick: first request at or after ptr, wrapping.
// Rev    : 1.0
// ============================================================================
module io_rr_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4
) (
    input  wire  [NUM_REQUESTERS-1:0] i_req,
    input  wire  io_requester_idx_t   i_ptr,
    output logic [NUM_REQUESTERS-1:0] o_grant,
    output io_requester_idx_t         o_grant_idx,
    output logic                      o_grant_valid
);

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!o_grant_valid && i_req[i] && (io_requester_idx_t'(i) >= i_ptr)) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = io_requester_idx_t'(i);
                o_grant[i]    = 1'b1;
            end
        end
        // Nothing at or above ptr: wrap to the lowest requester below it.
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!o_grant_valid && i_req[i]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = io_requester_idx_t'(i);
                o_grant[i]    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_arbiter.sv
`default_nettype none
// ============================================================================
// Module : io_arbiter
// Brief  : Round-robin sharing of the memory-mapped I/O bus with read routing.
// Rev    : 1.0
// ============================================================================
module io_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int READ_LATENCY   = 1
) (
    input wire          clk,
    input wire          reset_n,
    io_arbiter_if.slave bus
);

    logic [NUM_REQUESTERS-1:0] w_grant;
    io_requester_idx_t         w_grant_idx;
    logic                      w_grant_valid;

    io_requester_idx_t         r_ptr_q, w_ptr_d;
    io_requester_idx_t         r_cmd_idx_q, w_cmd_idx_d;
    logic                      r_io_write_en_q, w_io_write_en_d;
    logic                      r_io_read_en_q, w_io_read_en_d;
    logic [IO_ADDR_W-1:0]      r_io_address_q, w_io_address_d;
    logic [IO_DATA_W-1:0]      r_io_write_data_q, w_io_write_data_d;

    logic                      w_mat_valid;
    io_requester_idx_t         w_mat_idx;

    io_rr_arbiter #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_rr_arbiter (
        .i_req         (bus.req),
        .i_ptr         (r_ptr_q),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_comb begin
        w_ptr_d           = r_ptr_q;
        w_cmd_idx_d       = r_cmd_idx_q;
        w_io_write_en_d   = 1'b0;
        w_io_read_en_d    = 1'b0;
        w_io_address_d    = r_io_address_q;
        w_io_write_data_d = r_io_write_data_q;
        if (w_grant_valid) begin
            w_ptr_d     = io_next_ptr(w_grant_idx, NUM_REQUESTERS);
            w_cmd_idx_d = w_grant_idx;
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (w_grant[i]) begin
                w_io_write_en_d   = bus.req_write[i];
                w_io_read_en_d    = !bus.req_write[i];
                w_io_address_d    = bus.req_address[i];
                w_io_write_data_d = bus.req_write_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr_q           <= '0;
            r_cmd_idx_q       <= '0;
            r_io_write_en_q   <= 1'b0;
            r_io_read_en_q    <= 1'b0;
            r_io_address_q    <= '0;
            r_io_write_data_q <= '0;
        end else begin
            r_ptr_q           <= w_ptr_d;
            r_cmd_idx_q       <= w_cmd_idx_d;
            r_io_write_en_q   <= w_io_write_en_d;
            r_io_read_en_q    <= w_io_read_en_d;
            r_io_address_q    <= w_io_address_d;
            r_io_write_data_q <= w_io_write_data_d;
        end
    end

    // Read tracking: the strobe cycle's (valid, idx) travels READ_LATENCY stages.
    generate
        if (READ_LATENCY == 0) begin : g_lat0
            always_comb begin
                w_mat_valid = r_io_read_en_q;
                w_mat_idx   = r_cmd_idx_q;
            end
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] r_pipe_valid_q, w_pipe_valid_d;
            io_requester_idx_t       r_pipe_idx_q [READ_LATENCY];
            io_requester_idx_t       w_pipe_idx_d [READ_LATENCY];

            always_comb begin
                w_pipe_valid_d    = '0;
                w_pipe_valid_d[0] = r_io_read_en_q;
                w_pipe_idx_d[0]   = r_cmd_idx_q;
                for (int s = 1; s < READ_LATENCY; s++) begin
                    w_pipe_valid_d[s] = r_pipe_valid_q[s-1];
                    w_pipe_idx_d[s]   = r_pipe_idx_q[s-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe_valid_q <= '0;
                    for (int s = 0; s < READ_LATENCY; s++) begin
                        r_pipe_idx_q[s] <= '0;
                    end
                end else begin
                    r_pipe_valid_q <= w_pipe_valid_d;
                    for (int s = 0; s < READ_LATENCY; s++) begin
                        r_pipe_idx_q[s] <= w_pipe_idx_d[s];
                    end
                end
            end

            always_comb begin
                w_mat_valid = r_pipe_valid_q[READ_LATENCY-1];
                w_mat_idx   = r_pipe_idx_q[READ_LATENCY-1];
            end
        end
    endgenerate

    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        if (w_mat_valid) begin
            bus.resp_data = bus.io_read_data;
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (w_mat_idx == io_requester_idx_t'(i)) begin
                    bus.resp_valid[i] = 1'b1;
                end
            end
        end
    end

    assign bus.grant         = w_grant;
    assign bus.io_write_en   = r_io_write_en_q;
    assign bus.io_read_en    = r_io_read_en_q;
    assign bus.io_address    = r_io_address_q;
    assign bus.io_write_data = r_io_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_io_arbiter
// Brief  : Directed and random checks of io_arbiter against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_io_arbiter;

    localparam int NA = 4;
    localparam int LA = 2;
    localparam int NB = 3;
    localparam int LB = 0;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    io_arbiter_if #(.NUM_REQUESTERS(NA)) bus_a ();
    io_arbiter_if #(.NUM_REQUESTERS(NB)) bus_b ();

    io_arbiter #(.NUM_REQUESTERS(NA), .READ_LATENCY(LA)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    io_arbiter #(.NUM_REQUESTERS(NB), .READ_LATENCY(LB)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of DUT A: pointer, expected io bus state, pending reads.
    typedef struct { int due; int idx; } rd_t;
    rd_t         rq[$];
    int          m_ptr   = 0;
    logic        m_we    = 1'b0;
    logic        m_re    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    int          cyc     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_we = 1'b0; m_re = 1'b0; m_addr = '0; m_wdata = '0;
        rq.delete();
    endtask

    task automatic settle_check();
        int          w;
        logic [NA-1:0] eg, erv;
        logic [31:0] erd;
        rd_t         r;
        #1;
        w = -1;
        for (int k = 0; k < NA; k++) begin
            int j;
            j = (m_ptr + k) % NA;
            if (w < 0 && bus_a.req[j]) w = j;
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        erv = '0;
        erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].idx] = 1'b1;
            erd = bus_a.io_read_data;
            void'(rq.pop_front());
        end
        check("grant",         bus_a.grant,         eg);
        check("io_write_en",   bus_a.io_write_en,   m_we);
        check("io_read_en",    bus_a.io_read_en,    m_re);
        check("io_address",    bus_a.io_address,    m_addr);
        check("io_write_data", bus_a.io_write_data, m_wdata);
        check("resp_valid",    bus_a.resp_valid,    erv);
        check("resp_data",     bus_a.resp_data,     erd);
        if (w >= 0) begin
            m_ptr   = (w + 1) % NA;
            m_we    = bus_a.req_write[w];
            m_re    = !bus_a.req_write[w];
            m_addr  = bus_a.req_address[w];
            m_wdata = bus_a.req_write_data[w];
            if (m_re) begin
                r.due = cyc + 1 + LA;
                r.idx = w;
                rq.push_back(r);
            end
        end else begin
            m_we = 1'b0;
            m_re = 1'b0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    initial begin
        logic [NA-1:0] exp_g;
        bus_a.req = '0; bus_a.req_write = '0; bus_a.req_address = '0;
        bus_a.req_write_data = '0; bus_a.io_read_data = '0;
        bus_b.req = '0; bus_b.req_write = '0; bus_b.req_address = '0;
        bus_b.req_write_data = '0; bus_b.io_read_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // N=3, zero latency: pointer wraps from 2 to 0; response in the strobe cycle.
        bus_b.req = 3'b100; bus_b.req_address[2] = 32'h30; bus_b.req_address[0] = 32'h10;
        #1;
        check("b_grant_c0", bus_b.grant, 3'b100);
        check("b_rst_re",   bus_b.io_read_en, 1'b0);
        advance();
        bus_b.req = 3'b101; bus_b.io_read_data = 32'h55;
        #1;
        check("b_wrap_grant", bus_b.grant, 3'b001);
        check("b_re_c1",      bus_b.io_read_en, 1'b1);
        check("b_addr_c1",    bus_b.io_address, 32'h30);
        check("b_rv_c1",      bus_b.resp_valid, 3'b100);
        check("b_rd_c1",      bus_b.resp_data, 32'h55);
        advance();
        bus_b.req = 3'b100; bus_b.io_read_data = 32'h66;
        #1;
        check("b_grant_c2", bus_b.grant, 3'b100);
        check("b_rv_c2",    bus_b.resp_valid, 3'b001);
        check("b_rd_c2",    bus_b.resp_data, 32'h66);
        check("b_addr_c2",  bus_b.io_address, 32'h10);
        advance();
        bus_b.req = 3'b000; bus_b.io_read_data = 32'h77;
        #1;
        check("b_grant_c3", bus_b.grant, 3'b000);
        check("b_rv_c3",    bus_b.resp_valid, 3'b100);
        check("b_rd_c3",    bus_b.resp_data, 32'h77);
        advance();
        #1;
        check("b_rv_idle", bus_b.resp_valid, 3'b000);
        check("b_rd_idle", bus_b.resp_data, 32'h0);
        check("b_re_idle", bus_b.io_read_en, 1'b0);
        advance();
        bus_b.io_read_data = '0;

        // DUT A reset state.
        settle_check();
        check("a_rst_addr",  bus_a.io_address, 32'h0);
        check("a_rst_grant", bus_a.grant, 4'b0000);
        advance();

        // All four requesting from ptr=0: 0,1,2,3,0 with continuous strobes.
        bus_a.req = 4'hF; bus_a.req_write = 4'h0;
        for (int i = 0; i < NA; i++) bus_a.req_address[i] = 32'h100 + 32'(i * 4);
        for (int n = 0; n < 5; n++) begin
            settle_check();
            exp_g = '0; exp_g[n % NA] = 1'b1;
            check("a_rr_order", bus_a.grant, exp_g);
            if (n > 0) check("a_rr_strobe", bus_a.io_read_en, 1'b1);
            advance();
        end

        // Single write from requester 2.
        bus_a.req = 4'b0100; bus_a.req_write = 4'b0100;
        bus_a.req_address[2] = 32'h8; bus_a.req_write_data[2] = 32'h7F;
        settle_check();
        check("a_wr_grant", bus_a.grant, 4'b0100);
        advance();
        bus_a.req = '0;
        settle_check();
        check("a_wr_we",   bus_a.io_write_en, 1'b1);
        check("a_wr_addr", bus_a.io_address, 32'h8);
        check("a_wr_data", bus_a.io_write_data, 32'h7F);
        advance();

        // Grant 3 alone so ptr returns to 0, then 0 and 3 contend.
        bus_a.req = 4'b1000; bus_a.req_write = 4'b0000;
        step();
        bus_a.req = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            settle_check();
            check("a_fair", bus_a.grant, (n % 2 == 0) ? 4'b0001 : 4'b1000);
            advance();
        end
        bus_a.req = '0;
        repeat (4) step();

        // Back-to-back reads by 1 then 3; latency 2 returns at T+3 and T+4.
        bus_a.req = 4'b0010; step();
        bus_a.req = 4'b1000; step();
        bus_a.req = 4'b0000; step();
        bus_a.io_read_data = 32'hA;
        settle_check();
        check("a_b2b_rv1", bus_a.resp_valid, 4'b0010);
        check("a_b2b_rd1", bus_a.resp_data, 32'hA);
        advance();
        bus_a.io_read_data = 32'hB;
        settle_check();
        check("a_b2b_rv3", bus_a.resp_valid, 4'b1000);
        check("a_b2b_rd3", bus_a.resp_data, 32'hB);
        advance();
        bus_a.io_read_data = '0;

        // Reset one cycle after a read is issued: strobe drops at once, no response later.
        bus_a.req = 4'b0100; step();
        bus_a.req = '0;
        #2 reset_n = 1'b0;
        #1;
        check("a_arst_re",   bus_a.io_read_en, 1'b0);
        check("a_arst_we",   bus_a.io_write_en, 1'b0);
        check("a_arst_addr", bus_a.io_address, 32'h0);
        check("a_arst_rv",   bus_a.resp_valid, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cyc++;
        repeat (4) step();
        bus_a.req = 4'hF;
        settle_check();
        check("a_arst_ptr", bus_a.grant, 4'b0001);
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus_a.req       = 4'($urandom);
            bus_a.req_write = 4'($urandom);
            for (int i = 0; i < NA; i++) begin
                bus_a.req_address[i]    = $urandom;
                bus_a.req_write_data[i] = $urandom;
            end
            bus_a.io_read_data = $urandom;
            step();
        end
        bus_a.req = '0;
        repeat (LA + 3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
